// File: rtl/control_sequencer_if.sv
// Control-sequencer bus: opcode, flags and boot strobes in; every datapath
// control line plus step/instr_done debug out.
interface control_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int STEPS    = 5
);
    localparam int STEP_W = $clog2(STEPS);

    logic [OPCODE_W-1:0] instruction;
    logic                alu_carry;
    logic                alu_zero;
    logic                boot_en;
    logic                bootload_address;
    logic                bootload_ram;

    logic clk_halt;
    logic pc_inc;
    logic pc_jump;
    logic pc_out;
    logic a_reg_read_from_bus;
    logic a_reg_write_to_bus;
    logic b_reg_read_from_bus;
    logic b_reg_write_to_bus;
    logic i_reg_read_from_bus;
    logic i_reg_write_to_bus;
    logic mar_read_from_bus;
    logic ram_read_from_bus;
    logic ram_write_to_bus;
    logic alu_out;
    logic alu_subtract;
    logic alu_flags_in;
    logic out_en;
    logic boot_write_to_bus;

    logic [STEP_W-1:0] step;
    logic              instr_done;

    modport master (
        input  instruction, alu_carry, alu_zero, boot_en, bootload_address, bootload_ram,
        output clk_halt, pc_inc, pc_jump, pc_out,
        output a_reg_read_from_bus, a_reg_write_to_bus,
        output b_reg_read_from_bus, b_reg_write_to_bus,
        output i_reg_read_from_bus, i_reg_write_to_bus,
        output mar_read_from_bus, ram_read_from_bus, ram_write_to_bus,
        output alu_out, alu_subtract, alu_flags_in,
        output out_en, boot_write_to_bus,
        output step, instr_done
    );

    modport slave (
        output instruction, alu_carry, alu_zero, boot_en, bootload_address, bootload_ram,
        input  clk_halt, pc_inc, pc_jump, pc_out,
        input  a_reg_read_from_bus, a_reg_write_to_bus,
        input  b_reg_read_from_bus, b_reg_write_to_bus,
        input  i_reg_read_from_bus, i_reg_write_to_bus,
        input  mar_read_from_bus, ram_read_from_bus, ram_write_to_bus,
        input  alu_out, alu_subtract, alu_flags_in,
        input  out_en, boot_write_to_bus,
        input  step, instr_done
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded T-state control sequencer for the 8-bit CPU with BOOT/RUN/HALT
// modes, optional early instruction end and conditional jumps.
module control_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int STEPS     = 5,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master bus
);
    localparam int STEP_W = $clog2(STEPS);

    localparam logic [STEP_W-1:0] T0        = '0;
    localparam logic [STEP_W-1:0] T1        = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2        = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3        = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4        = STEP_W'(4);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic clk_halt;
        logic pc_inc;
        logic pc_jump;
        logic pc_out;
        logic a_rd;
        logic a_wr;
        logic b_rd;
        logic b_wr;
        logic i_rd;
        logic i_wr;
        logic mar_rd;
        logic ram_rd;
        logic ram_wr;
        logic alu_out;
        logic alu_sub;
        logic alu_flags;
        logic out_en;
        logic boot_wr;
        logic instr_done;
    } ctl_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [STEP_W-1:0]   w_last_active;
    logic [STEP_W-1:0]   w_last;
    logic [OPCODE_W-1:0] w_upper;
    logic [3:0]          w_op;
    ctl_t                w_ctl;
    ctl_t                w_ctl_out;

    // Any nonzero bit above [3:0] demotes the opcode to NOP.
    assign w_upper = bus.instruction >> 4;
    assign w_op    = (w_upper == '0) ? bus.instruction[3:0] : OP_NOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_last_active = T1;
        case (w_op)
            OP_LDA, OP_STA:                                   w_last_active = T3;
            OP_ADD, OP_SUB:                                   w_last_active = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:     w_last_active = T2;
            default:                                          w_last_active = T1;
        endcase
        // HLT never pads: it leaves for HALT straight out of T2.
        w_last = (w_op == OP_HLT || EARLY_END != 0) ? w_last_active : STEP_LAST;
    end

    always_comb begin
        w_ctl       = '0;
        w_state_nxt = r_state;
        w_step_nxt  = r_step;

        case (r_state)
            ST_BOOT: begin
                if (bus.bootload_address) begin
                    w_ctl.boot_wr = 1'b1;
                    w_ctl.mar_rd  = 1'b1;
                end else if (bus.bootload_ram) begin
                    w_ctl.boot_wr = 1'b1;
                    w_ctl.ram_rd  = 1'b1;
                end
                w_step_nxt = '0;
                if (!bus.boot_en) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_HALT: begin
                w_ctl.clk_halt = 1'b1;
            end

            default: begin
                w_ctl.instr_done = (r_step == w_last);
                case (r_step)
                    T0: begin
                        w_ctl.pc_out = 1'b1;
                        w_ctl.mar_rd = 1'b1;
                    end
                    T1: begin
                        w_ctl.ram_wr = 1'b1;
                        w_ctl.i_rd   = 1'b1;
                        w_ctl.pc_inc = 1'b1;
                    end
                    T2: begin
                        case (w_op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                w_ctl.i_wr   = 1'b1;
                                w_ctl.mar_rd = 1'b1;
                            end
                            OP_LDI: begin
                                w_ctl.i_wr = 1'b1;
                                w_ctl.a_rd = 1'b1;
                            end
                            OP_JMP: begin
                                w_ctl.i_wr    = 1'b1;
                                w_ctl.pc_jump = 1'b1;
                            end
                            OP_JC: begin
                                w_ctl.i_wr    = bus.alu_carry;
                                w_ctl.pc_jump = bus.alu_carry;
                            end
                            OP_JZ: begin
                                w_ctl.i_wr    = bus.alu_zero;
                                w_ctl.pc_jump = bus.alu_zero;
                            end
                            OP_OUT: begin
                                w_ctl.a_wr   = 1'b1;
                                w_ctl.out_en = 1'b1;
                            end
                            OP_HLT: w_ctl.clk_halt = 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (w_op)
                            OP_LDA: begin
                                w_ctl.ram_wr = 1'b1;
                                w_ctl.a_rd   = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                w_ctl.ram_wr  = 1'b1;
                                w_ctl.b_rd    = 1'b1;
                                w_ctl.alu_sub = (w_op == OP_SUB);
                            end
                            OP_STA: begin
                                w_ctl.a_wr   = 1'b1;
                                w_ctl.ram_rd = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (w_op == OP_ADD || w_op == OP_SUB) begin
                            w_ctl.alu_out   = 1'b1;
                            w_ctl.a_rd      = 1'b1;
                            w_ctl.alu_flags = 1'b1;
                            w_ctl.alu_sub   = (w_op == OP_SUB);
                        end
                    end
                    default: ;
                endcase

                // >= also recovers if the opcode shortens mid-instruction.
                if (w_op == OP_HLT && r_step == T2) begin
                    w_state_nxt = ST_HALT;
                end else if (r_step >= w_last) begin
                    w_step_nxt = '0;
                end else begin
                    w_step_nxt = r_step + STEP_W'(1);
                end
            end
        endcase

        if (bus.boot_en) begin
            w_state_nxt = ST_BOOT;
            w_step_nxt  = '0;
        end
    end

    assign w_ctl_out = rst ? '0 : w_ctl;

    assign bus.clk_halt            = w_ctl_out.clk_halt;
    assign bus.pc_inc              = w_ctl_out.pc_inc;
    assign bus.pc_jump             = w_ctl_out.pc_jump;
    assign bus.pc_out              = w_ctl_out.pc_out;
    assign bus.a_reg_read_from_bus = w_ctl_out.a_rd;
    assign bus.a_reg_write_to_bus  = w_ctl_out.a_wr;
    assign bus.b_reg_read_from_bus = w_ctl_out.b_rd;
    assign bus.b_reg_write_to_bus  = w_ctl_out.b_wr;
    assign bus.i_reg_read_from_bus = w_ctl_out.i_rd;
    assign bus.i_reg_write_to_bus  = w_ctl_out.i_wr;
    assign bus.mar_read_from_bus   = w_ctl_out.mar_rd;
    assign bus.ram_read_from_bus   = w_ctl_out.ram_rd;
    assign bus.ram_write_to_bus    = w_ctl_out.ram_wr;
    assign bus.alu_out             = w_ctl_out.alu_out;
    assign bus.alu_subtract        = w_ctl_out.alu_sub;
    assign bus.alu_flags_in        = w_ctl_out.alu_flags;
    assign bus.out_en              = w_ctl_out.out_en;
    assign bus.boot_write_to_bus   = w_ctl_out.boot_wr;
    assign bus.instr_done          = w_ctl_out.instr_done;
    assign bus.step                = r_step;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: dut0 (EARLY_END=1, STEPS=5) and
// dut1 (OPCODE_W=5, STEPS=6, EARLY_END=0) share one stimulus set.
module tb_control_sequencer;
    localparam logic [17:0] HLT  = 18'h1 << 17;
    localparam logic [17:0] PCI  = 18'h1 << 16;
    localparam logic [17:0] PCJ  = 18'h1 << 15;
    localparam logic [17:0] PCO  = 18'h1 << 14;
    localparam logic [17:0] ARR  = 18'h1 << 13;
    localparam logic [17:0] AW   = 18'h1 << 12;
    localparam logic [17:0] BRR  = 18'h1 << 11;
    localparam logic [17:0] IRR  = 18'h1 << 9;
    localparam logic [17:0] IW   = 18'h1 << 8;
    localparam logic [17:0] MARR = 18'h1 << 7;
    localparam logic [17:0] RAMR = 18'h1 << 6;
    localparam logic [17:0] RAMW = 18'h1 << 5;
    localparam logic [17:0] ALUO = 18'h1 << 4;
    localparam logic [17:0] SUB  = 18'h1 << 3;
    localparam logic [17:0] FLG  = 18'h1 << 2;
    localparam logic [17:0] OUTE = 18'h1 << 1;
    localparam logic [17:0] BOOTW = 18'h1;

    typedef struct {
        string       name;
        bit          sel;
        logic [17:0] ctl;
        logic [2:0]  step;
        logic        done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] instruction = '0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic       boot_en = 1'b0;
    logic       bl_addr = 1'b0;
    logic       bl_ram = 1'b0;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    control_sequencer_if #(.OPCODE_W(4), .STEPS(5)) bus0();
    control_sequencer_if #(.OPCODE_W(5), .STEPS(6)) bus1();

    assign bus0.instruction      = instruction[3:0];
    assign bus0.alu_carry        = alu_carry;
    assign bus0.alu_zero         = alu_zero;
    assign bus0.boot_en          = boot_en;
    assign bus0.bootload_address = bl_addr;
    assign bus0.bootload_ram     = bl_ram;
    assign bus1.instruction      = instruction;
    assign bus1.alu_carry        = alu_carry;
    assign bus1.alu_zero         = alu_zero;
    assign bus1.boot_en          = boot_en;
    assign bus1.bootload_address = bl_addr;
    assign bus1.bootload_ram     = bl_ram;

    control_sequencer #(.OPCODE_W(4), .STEPS(5), .EARLY_END(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.master)
    );
    control_sequencer #(.OPCODE_W(5), .STEPS(6), .EARLY_END(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );

    logic [17:0] act0, act1;
    assign act0 = {bus0.clk_halt, bus0.pc_inc, bus0.pc_jump, bus0.pc_out,
                   bus0.a_reg_read_from_bus, bus0.a_reg_write_to_bus,
                   bus0.b_reg_read_from_bus, bus0.b_reg_write_to_bus,
                   bus0.i_reg_read_from_bus, bus0.i_reg_write_to_bus,
                   bus0.mar_read_from_bus, bus0.ram_read_from_bus, bus0.ram_write_to_bus,
                   bus0.alu_out, bus0.alu_subtract, bus0.alu_flags_in,
                   bus0.out_en, bus0.boot_write_to_bus};
    assign act1 = {bus1.clk_halt, bus1.pc_inc, bus1.pc_jump, bus1.pc_out,
                   bus1.a_reg_read_from_bus, bus1.a_reg_write_to_bus,
                   bus1.b_reg_read_from_bus, bus1.b_reg_write_to_bus,
                   bus1.i_reg_read_from_bus, bus1.i_reg_write_to_bus,
                   bus1.mar_read_from_bus, bus1.ram_read_from_bus, bus1.ram_write_to_bus,
                   bus1.alu_out, bus1.alu_subtract, bus1.alu_flags_in,
                   bus1.out_en, bus1.boot_write_to_bus};

    always #5 clk = ~clk;

    task automatic push(input string name, input bit sel, input logic [17:0] ctl,
                        input int step, input logic done);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.ctl  = ctl;
        e.step = 3'(step);
        e.done = done;
        sb.push_back(e);
    endtask

    // One queued expectation per cycle, sampled on the falling edge.
    task automatic drain();
        exp_t        e;
        logic [17:0] a_ctl;
        logic [2:0]  a_step;
        logic        a_done;
        while (sb.size() > 0) begin
            @(negedge clk);
            e      = sb.pop_front();
            a_ctl  = e.sel ? act1 : act0;
            a_step = e.sel ? bus1.step : bus0.step;
            a_done = e.sel ? bus1.instr_done : bus0.instr_done;
            n_tests++;
            if ({a_ctl, a_step, a_done} !== {e.ctl, e.step, e.done}) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b step=%0d done=%b, expected ctl=%b step=%0d done=%b",
                         e.name, a_ctl, a_step, a_done, e.ctl, e.step, e.done);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Expected dut0 sequence for one instruction, straight from the microcode table.
    task automatic push_instr(input int op, input logic c, input logic z);
        logic [17:0] s2, s3, s4;
        int          last;
        s2 = '0; s3 = '0; s4 = '0; last = 1;
        case (op)
            1:  begin s2 = IW | MARR; s3 = RAMW | ARR; last = 3; end
            2:  begin s2 = IW | MARR; s3 = RAMW | BRR; s4 = ALUO | ARR | FLG; last = 4; end
            3:  begin s2 = IW | MARR; s3 = RAMW | BRR | SUB; s4 = ALUO | ARR | FLG | SUB; last = 4; end
            4:  begin s2 = IW | MARR; s3 = AW | RAMR; last = 3; end
            5:  begin s2 = IW | ARR; last = 2; end
            6:  begin s2 = IW | PCJ; last = 2; end
            7:  begin s2 = c ? (IW | PCJ) : 18'h0; last = 2; end
            8:  begin s2 = z ? (IW | PCJ) : 18'h0; last = 2; end
            14: begin s2 = AW | OUTE; last = 2; end
            15: begin s2 = HLT; last = 2; end
            default: last = 1;
        endcase
        push($sformatf("op%0d_T0", op), 0, PCO | MARR, 0, 1'b0);
        push($sformatf("op%0d_T1", op), 0, RAMW | IRR | PCI, 1, last == 1);
        if (last >= 2) push($sformatf("op%0d_T2", op), 0, s2, 2, last == 2);
        if (last >= 3) push($sformatf("op%0d_T3", op), 0, s3, 3, last == 3);
        if (last >= 4) push($sformatf("op%0d_T4", op), 0, s4, 4, last == 4);
    endtask

    task automatic resync();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (act0 !== 18'h0 || bus0.step !== 3'd0 || bus0.instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got ctl=%b step=%0d done=%b, expected all 0", act0, bus0.step, bus0.instr_done);
        end
        push("reset_cycle", 0, 18'h0, 0, 1'b0);
        drain();
        rst = 1'b0;
        instruction = 5'd0;
        push_instr(0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_add();
        instruction = 5'd2;
        push_instr(2, 1'b0, 1'b0);
        drain();
        instruction = 5'd0;
        push_instr(0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid();
        instruction = 5'd2;
        push("add_T0", 0, PCO | MARR, 0, 1'b0);
        push("add_T1", 0, RAMW | IRR | PCI, 1, 1'b0);
        push("add_T2", 0, IW | MARR, 2, 1'b0);
        drain();
        n_tests++;
        if (act0 !== (RAMW | BRR)) begin
            n_fail++;
            $display("FAIL add_T3_before_rst: got ctl=%b, expected %b", act0, RAMW | BRR);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (act0 !== 18'h0 || bus0.step !== 3'd0 || bus0.instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_drop: got ctl=%b step=%0d done=%b, expected all 0", act0, bus0.step, bus0.instr_done);
        end
        push("rst_mid_cycle", 0, 18'h0, 0, 1'b0);
        drain();
        rst = 1'b0;
        push_instr(2, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_jumps();
        for (int k = 0; k < 4; k++) begin
            instruction = (k < 2) ? 5'd7 : 5'd8;
            alu_carry   = (k == 1);
            alu_zero    = (k == 3);
            push_instr(int'(instruction), alu_carry, alu_zero);
            drain();
        end
        alu_carry = 1'b0;
        alu_zero  = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ops[10] = '{1, 3, 4, 5, 6, 14, 9, 12, 0, 2};
        for (int k = 0; k < 10; k++) begin
            instruction = 5'(ops[k]);
            alu_carry   = 1'($urandom_range(1));
            alu_zero    = 1'($urandom_range(1));
            push_instr(ops[k], alu_carry, alu_zero);
            drain();
        end
    endtask

    task automatic test_pad();
        resync();
        instruction = 5'd5;
        push("pad_T0", 1, PCO | MARR, 0, 1'b0);
        push("pad_T1", 1, RAMW | IRR | PCI, 1, 1'b0);
        push("pad_T2", 1, IW | ARR, 2, 1'b0);
        push("pad_T3", 1, 18'h0, 3, 1'b0);
        push("pad_T4", 1, 18'h0, 4, 1'b0);
        push("pad_T5", 1, 18'h0, 5, 1'b1);
        push("pad_wrap", 1, PCO | MARR, 0, 1'b0);
        drain();
        resync();
        instruction = 5'b10110;
        push("wide_T0", 1, PCO | MARR, 0, 1'b0);
        push("wide_T1", 1, RAMW | IRR | PCI, 1, 1'b0);
        push("wide_T2", 1, 18'h0, 2, 1'b0);
        push("wide_T3", 1, 18'h0, 3, 1'b0);
        push("wide_T4", 1, 18'h0, 4, 1'b0);
        push("wide_T5", 1, 18'h0, 5, 1'b1);
        drain();
        instruction = 5'd0;
        resync();
    endtask

    task automatic test_halt_boot();
        instruction = 5'd15;
        push_instr(15, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) push($sformatf("halt_%0d", k), 0, HLT, 2, 1'b0);
        drain();
        boot_en = 1'b1;
        push("halt_boot_req", 0, HLT, 2, 1'b0);
        push("boot_idle", 0, 18'h0, 0, 1'b0);
        drain();
        bl_addr = 1'b1; bl_ram = 1'b1;
        push("boot_both", 0, BOOTW | MARR, 0, 1'b0);
        drain();
        bl_addr = 1'b0;
        push("boot_ram", 0, BOOTW | RAMR, 0, 1'b0);
        drain();
        bl_addr = 1'b1; bl_ram = 1'b0;
        push("boot_addr", 0, BOOTW | MARR, 0, 1'b0);
        drain();
        boot_en = 1'b0; bl_addr = 1'b0;
        instruction = 5'd0;
        push("boot_exit", 0, 18'h0, 0, 1'b0);
        push_instr(0, 1'b0, 1'b0);
        drain();
        instruction = 5'd1;
        push("lda_T0", 0, PCO | MARR, 0, 1'b0);
        push("lda_T1", 0, RAMW | IRR | PCI, 1, 1'b0);
        drain();
        boot_en = 1'b1;
        push("lda_T2_boot_req", 0, IW | MARR, 2, 1'b0);
        push("boot_from_run", 0, 18'h0, 0, 1'b0);
        drain();
        boot_en = 1'b0;
        push("boot_exit2", 0, 18'h0, 0, 1'b0);
        push_instr(1, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_reset_mid();
        test_jumps();
        test_back_to_back();
        test_pad();
        test_halt_boot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
